// File: rtl/xif_alu_coproc_if.sv
// CV-X-IF signal bundle shared by the core and the custom-0 ALU coprocessor.
interface if_xif #(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned MEM_REQ_W = 32 + DATA_W + ID_W + 4;

   logic                   compressed_valid;
   logic                   compressed_ready;
   logic [15:0]            compressed_req_instr;
   logic [31:0]            compressed_resp_instr;
   logic                   compressed_resp_accept;

   logic                   issue_valid;
   logic                   issue_ready;
   logic [31:0]            issue_req_instr;
   logic [ID_W-1:0]        issue_req_id;
   logic [1:0][DATA_W-1:0] issue_req_rs;
   logic                   issue_resp_accept;
   logic                   issue_resp_writeback;
   logic                   issue_resp_dualwrite;
   logic                   issue_resp_dualread;
   logic                   issue_resp_loadstore;
   logic                   issue_resp_ecswrite;
   logic                   issue_resp_exc;

   logic                   commit_valid;
   logic [ID_W-1:0]        commit_id;
   logic                   commit_kill;

   logic                   mem_valid;
   logic                   mem_ready;
   logic [MEM_REQ_W-1:0]   mem_req;

   logic                   result_valid;
   logic                   result_ready;
   logic [ID_W-1:0]        result_id;
   logic [DATA_W-1:0]      result_data;
   logic [4:0]             result_rd;
   logic                   result_we;
   logic [5:0]             result_ecsdata;
   logic [2:0]             result_ecswe;
   logic                   result_exc;
   logic [5:0]             result_exccode;
   logic                   result_err;
   logic                   result_dbg;

   modport coproc_compressed (
      input  compressed_valid, compressed_req_instr,
      output compressed_ready, compressed_resp_instr, compressed_resp_accept
   );
   modport coproc_issue (
      input  issue_valid, issue_req_instr, issue_req_id, issue_req_rs,
      output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
             issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc
   );
   modport coproc_commit (
      input  commit_valid, commit_id, commit_kill
   );
   modport coproc_mem (
      input  mem_ready,
      output mem_valid, mem_req
   );
   modport coproc_result (
      input  result_ready,
      output result_valid, result_id, result_data, result_rd, result_we, result_ecsdata,
             result_ecswe, result_exc, result_exccode, result_err, result_dbg
   );
endinterface

// File: rtl/xif_alu_coproc.sv
// CV-X-IF coprocessor for custom-0 ALU ops with an ordered in-flight buffer.
// Optional MUL (funct3 5) is enabled by defining XIF_ALU_COPROC_MUL_EN.
module xif_alu_coproc #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ID_W    = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   if_xif.coproc_compressed xif_compressed_if,
   if_xif.coproc_issue      xif_issue_if,
   if_xif.coproc_commit     xif_commit_if,
   if_xif.coproc_mem        xif_mem_if,
   if_xif.coproc_result     xif_result_if,
   output logic             busy_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
   localparam int unsigned LAT_W = 3;
   localparam logic [6:0]  OPC_CUSTOM0 = 7'h0B;
   localparam logic [6:0]  FUNCT7_ALU  = 7'h01;
`ifdef XIF_ALU_COPROC_MUL_EN
   localparam logic [2:0]  F3_LAST = 3'd5;
`else
   localparam logic [2:0]  F3_LAST = 3'd4;
`endif

   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0]             committed_q, committed_d;
   logic [DEPTH-1:0]             killed_q, killed_d;
   logic [DEPTH-1:0][ID_W-1:0]   id_q, id_d;
   logic [DEPTH-1:0][4:0]        rd_q, rd_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   logic [DEPTH-1:0][LAT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
   logic [OCC_W-1:0]             occ_q, occ_d;
   logic                         busy_q, busy_d;

   logic [31:0]       instr_c;
   logic [2:0]        funct3_c;
   logic [DATA_W-1:0] rs1_c, rs2_c, alu_res_c;
   logic              ours_c, full_c, alloc_c, res_valid_c, pop_c, new_hit_c;
   logic              unused_inputs;

   assign instr_c  = xif_issue_if.issue_req_instr;
   assign funct3_c = instr_c[14:12];
   assign rs1_c    = xif_issue_if.issue_req_rs[0];
   assign rs2_c    = xif_issue_if.issue_req_rs[1];
   assign ours_c   = (instr_c[6:0] == OPC_CUSTOM0) && (instr_c[31:25] == FUNCT7_ALU)
                     && (funct3_c <= F3_LAST);
   // Only registered occupancy counts; a pop in this cycle does not free a slot yet.
   assign full_c   = (occ_q == OCC_W'(DEPTH));
   assign alloc_c  = xif_issue_if.issue_valid && ours_c && !full_c && rst_ni;

   assign res_valid_c = valid_q[head_q] && committed_q[head_q] && !killed_q[head_q]
                        && (cnt_q[head_q] == '0);
   assign pop_c       = valid_q[head_q]
                        && (killed_q[head_q] || (res_valid_c && xif_result_if.result_ready));
   assign new_hit_c   = xif_commit_if.commit_valid
                        && (xif_commit_if.commit_id == xif_issue_if.issue_req_id);

   // Operation datapath evaluated at issue and stored in the entry.
   always_comb begin : alu
      alu_res_c = '0;
      case (funct3_c)
         3'd0:    alu_res_c = rs1_c + rs2_c;
         3'd1:    alu_res_c = rs1_c - rs2_c;
         3'd2:    alu_res_c = rs1_c ^ rs2_c;
         3'd3:    alu_res_c = ($signed(rs1_c) < $signed(rs2_c)) ? rs1_c : rs2_c;
         3'd4:    alu_res_c = (rs1_c > rs2_c) ? rs1_c : rs2_c;
`ifdef XIF_ALU_COPROC_MUL_EN
         3'd5:    alu_res_c = DATA_W'(rs1_c * rs2_c);
`endif
         default: alu_res_c = '0;
      endcase
   end

   always_comb begin : next_state
      valid_d     = valid_q;
      committed_d = committed_q;
      killed_d    = killed_q;
      id_d        = id_q;
      rd_d        = rd_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      head_d      = head_q;
      tail_d      = tail_q;

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - LAT_W'(1);
         end
         if (xif_commit_if.commit_valid && valid_q[i] && (id_q[i] == xif_commit_if.commit_id)) begin
            if (!xif_commit_if.commit_kill) begin
               committed_d[i] = 1'b1;
            end else if (!committed_q[i]) begin
               killed_d[i] = 1'b1;
            end
         end
      end

      // A commit for the id being issued this cycle lands on the new entry.
      if (alloc_c) begin
         valid_d[tail_q]     = 1'b1;
         id_d[tail_q]        = xif_issue_if.issue_req_id;
         rd_d[tail_q]        = instr_c[11:7];
         data_d[tail_q]      = alu_res_c;
         cnt_d[tail_q]       = LAT_W'(LATENCY);
         committed_d[tail_q] = new_hit_c && !xif_commit_if.commit_kill;
         killed_d[tail_q]    = new_hit_c && xif_commit_if.commit_kill;
         tail_d              = tail_q + PTR_W'(1);
      end

      if (pop_c) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end

      occ_d  = occ_q + OCC_W'(alloc_c) - OCC_W'(pop_c);
      busy_d = (occ_d != '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
      if (!rst_ni) begin
         valid_q     <= '0;
         committed_q <= '0;
         killed_q    <= '0;
         id_q        <= '0;
         rd_q        <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         occ_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         committed_q <= committed_d;
         killed_q    <= killed_d;
         id_q        <= id_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         busy_q      <= busy_d;
      end
   end

   assign busy_o = busy_q;

   assign xif_issue_if.issue_ready          = !full_c || !ours_c;
   assign xif_issue_if.issue_resp_accept    = ours_c && !full_c && rst_ni;
   assign xif_issue_if.issue_resp_writeback = ours_c && !full_c && rst_ni;
   assign xif_issue_if.issue_resp_dualwrite = 1'b0;
   assign xif_issue_if.issue_resp_dualread  = 1'b0;
   assign xif_issue_if.issue_resp_loadstore = 1'b0;
   assign xif_issue_if.issue_resp_ecswrite  = 1'b0;
   assign xif_issue_if.issue_resp_exc       = 1'b0;

   assign xif_result_if.result_valid   = res_valid_c;
   assign xif_result_if.result_id      = id_q[head_q];
   assign xif_result_if.result_rd      = rd_q[head_q];
   assign xif_result_if.result_data    = data_q[head_q];
   assign xif_result_if.result_we      = 1'b1;
   assign xif_result_if.result_ecsdata = '0;
   assign xif_result_if.result_ecswe   = '0;
   assign xif_result_if.result_exc     = 1'b0;
   assign xif_result_if.result_exccode = '0;
   assign xif_result_if.result_err     = 1'b0;
   assign xif_result_if.result_dbg     = 1'b0;

   // Compressed instructions are never ours; the memory channel is never used.
   assign xif_compressed_if.compressed_ready       = 1'b1;
   assign xif_compressed_if.compressed_resp_accept = 1'b0;
   assign xif_compressed_if.compressed_resp_instr  = 32'h0000_0013;
   assign xif_mem_if.mem_valid = 1'b0;
   assign xif_mem_if.mem_req   = '0;

   assign unused_inputs = ^{xif_compressed_if.compressed_valid, xif_compressed_if.compressed_req_instr,
                            xif_mem_if.mem_ready, instr_c[24:15]};
endmodule
